idma_sync_256b_req_arbiter: RTL and testbench
=============================================

Name: idma_sync_256b_req_arbiter

Overview:
- Shares one idma_sync_256b engine among NUM_REQ requesters, for example the NoC interface block and a local core-side DMA launcher.
- Runs independent read-channel and write-channel arbiters. Each uses round-robin selection and locks its grant from command acceptance until the transfer completes.
- Routes read data back to the read owner only, and write data and wr_done_intr from/to the write owner only.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 32, DMA address width
- DATA_WIDTH, 256, data beat width
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- IDX_W, $clog2(NUM_REQ), owner index width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_rd_req  in  NUM_REQ  per-requester read command valid
- s_rd_addr  in  NUM_REQ*ADDR_WIDTH  read address, requester i at slice i
- s_rd_num  in  NUM_REQ*32  read length in 32-bit words
- s_rd_addr_ready  out  NUM_REQ  read command accepted
- s_rd_data_valid  out  NUM_REQ  read beat valid, owner bit only
- s_rd_data  out  DATA_WIDTH  read data, broadcast
- s_rd_data_ready  in  NUM_REQ  read beat ready
- s_wr_req / s_wr_addr / s_wr_num / s_wr_addr_ready  as the read command ports
- s_wr_data_valid  in  NUM_REQ  write beat valid
- s_wr_data  in  NUM_REQ*DATA_WIDTH  write data
- s_wr_strb  in  NUM_REQ*STRB_WIDTH  write strobes
- s_wr_data_ready  out  NUM_REQ  write beat ready
- s_wr_done  out  NUM_REQ  one-cycle write-done pulse to the owner
- rd_req, rd_addr, rd_num, rd_addr_ready, rd_data_valid, rd_data, rd_data_ready  (iDMA read side; standard directions toward the engine)
- wr_req, wr_addr, wr_num, wr_addr_ready, wr_data_valid, wr_data, wr_data_ready, wr_strb, wr_done_intr  (iDMA write side)
- rd_busy, wr_busy  out  1  channel locked
- rd_owner, wr_owner  out  IDX_W  current owner index

Behaviour:
- Reset values: rd_req=0, wr_req=0, all s_*_ready=0, s_rd_data_valid=0, s_wr_done=0, busy=0, owner=0, RR pointers=0, beat counter=0, both FSMs in IDLE.
- Each channel FSM has three states: IDLE, CMD, DATA.
- IDLE:
  - If any s_x_req is set, the round-robin picker selects the first requester at or after rr_ptr (wrapping).
  - Register the owner and its addr/num. Go to CMD next cycle, so rd_req/wr_req asserts 1 cycle after s_x_req.
  - Requests seen in IDLE are sampled; the requester must hold s_x_req until s_x_addr_ready.
- CMD:
  - Drive x_req=1 with the registered addr/num.
  - On the x_req && x_addr_ready handshake: pulse s_x_addr_ready[owner] for 1 cycle and set rr_ptr=owner+1 mod NUM_REQ.
  - Read channel: load beats = rd_num[31:3] + |rd_num[2:0]. If beats==0, go to IDLE; otherwise go to DATA.
  - Write channel: always go to DATA.
- DATA (read):
  - s_rd_data_valid[owner]=rd_data_valid; rd_data_ready=s_rd_data_ready[owner]; all other requesters see valid=0.
  - Decrement the beat counter on each handshake. When the handshake occurs at count==1, go to IDLE.
  - Combinational pass-through, 0 cycles of added latency.
- DATA (write):
  - wr_data_valid, wr_data and wr_strb are muxed from the owner; s_wr_data_ready[owner]=wr_data_ready.
  - On wr_done_intr: pulse s_wr_done[owner] for 1 cycle and go to IDLE.
  - wr_done_intr in IDLE or CMD is ignored.
- Channel independence: the read and write channels are fully independent and may have the same or different owners concurrently.
- Grant timing: a grant changes only in IDLE, so there are no mid-transfer switches. The back-to-back minimum is 1 idle cycle between transfers.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0.
- Non-owner requesters see s_x_addr_ready=0 and data ready/valid=0 at all times.
- Reset mid-transfer: all state returns to the reset values immediately. Any in-flight iDMA transfer is the system's responsibility; the arbiter does not track it after reset.

Decomposition:
- Package idma_arb_pkg holds:
  - the channel state enum (IDLE/CMD/DATA)
  - function num_to_beats (words to ceil beats)
  - localparam WORDS_PER_BEAT=DATA_WIDTH/32
- Sub-module idma_rr_arb: parameterized round-robin picker, taking req[NUM_REQ] and ptr and producing one-hot gnt plus idx (combinational). It is instantiated once per channel.

Test Plan:
- Single read: req0 issues rd_num=32 → rd_req one cycle later. After addr_ready, exactly 4 beats are routed to requester 0 only, then rd_busy=0.
- Simultaneous reads from 0 and 1 after reset → 0 served first, then 1. A subsequent repeat from both → order 0,1 (ptr wraps). No overlap of s_rd_data_valid bits.
- Concurrent traffic: read by req1 (rd_num=16) and write by req0 (wr_num=24, 3 beats) → both channels busy together. Data is routed correctly; s_wr_done[0] pulses once on wr_done_intr.
- Boundary: rd_num=0 returns to IDLE after the command handshake with no DATA phase. rd_num=9 yields 2 beats.
- Backpressure: owner holds s_rd_data_ready=0 for 5 cycles mid-transfer → rd_data_ready=0, no beat lost, counter unchanged.
- Reset mid-transfer: assert rst_n=0 during read DATA → rd_req=0, busy=0, owner=0. A new request after reset is served normally.

Source files
------------

// File: rtl/idma_sync_256b_req_arbiter_pkg.sv
// Shared types and helpers for the iDMA request arbiter: channel FSM encoding
// and word-count to beat-count conversion for 256-bit beats.
package idma_arb_pkg;

   localparam int IDMA_DATA_WIDTH = 256;
   localparam int WORDS_PER_BEAT  = IDMA_DATA_WIDTH / 32;
   localparam int WPB_SHIFT       = $clog2(WORDS_PER_BEAT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } chan_state_e;

   // Ceiling division without widening: partial trailing beat adds one.
   function automatic logic [31:0] num_to_beats(input logic [31:0] num);
      logic [31:0] mask;
      mask = 32'(WORDS_PER_BEAT - 1);
      return (num >> WPB_SHIFT) + 32'(|(num & mask));
   endfunction

endpackage

// File: rtl/idma_sync_256b_req_arbiter_if.sv
// Engine-side bundle of the idma_sync_256b read and write channels.
interface idma_sync_256b_req_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 256,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic                  rd_req;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [31:0]           rd_num;
   logic                  rd_addr_ready;
   logic                  rd_data_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_data_ready;
   logic                  wr_req;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [31:0]           wr_num;
   logic                  wr_addr_ready;
   logic                  wr_data_valid;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_data_ready;
   logic [STRB_WIDTH-1:0] wr_strb;
   logic                  wr_done_intr;

   modport master (
      output rd_req, rd_addr, rd_num, rd_data_ready,
             wr_req, wr_addr, wr_num, wr_data_valid, wr_data, wr_strb,
      input  rd_addr_ready, rd_data_valid, rd_data,
             wr_addr_ready, wr_data_ready, wr_done_intr
   );

   modport slave (
      input  rd_req, rd_addr, rd_num, rd_data_ready,
             wr_req, wr_addr, wr_num, wr_data_valid, wr_data, wr_strb,
      output rd_addr_ready, rd_data_valid, rd_data,
             wr_addr_ready, wr_data_ready, wr_done_intr
   );
endinterface

// File: rtl/idma_sync_256b_req_arbiter_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module idma_rr_arb #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx
);
   // Walk offsets from farthest to nearest so the nearest match wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % NUM_REQ]) begin
            gnt = '0;
            gnt[(int'(ptr) + i) % NUM_REQ] = 1'b1;
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
         end
      end
   end
endmodule

// File: rtl/idma_sync_256b_req_arbiter.sv
// Shares one idma_sync_256b engine among NUM_REQ requesters with independent,
// grant-locked round-robin arbitration on the read and write channels.
module idma_sync_256b_req_arbiter
   import idma_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 256,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int IDX_W      = $clog2(NUM_REQ)
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_REQ-1:0]                    s_rd_req,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    s_rd_addr,
   input  logic [NUM_REQ-1:0][31:0]              s_rd_num,
   output logic [NUM_REQ-1:0]                    s_rd_addr_ready,
   output logic [NUM_REQ-1:0]                    s_rd_data_valid,
   output logic [DATA_WIDTH-1:0]                 s_rd_data,
   input  logic [NUM_REQ-1:0]                    s_rd_data_ready,
   input  logic [NUM_REQ-1:0]                    s_wr_req,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    s_wr_addr,
   input  logic [NUM_REQ-1:0][31:0]              s_wr_num,
   output logic [NUM_REQ-1:0]                    s_wr_addr_ready,
   input  logic [NUM_REQ-1:0]                    s_wr_data_valid,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    s_wr_data,
   input  logic [NUM_REQ-1:0][STRB_WIDTH-1:0]    s_wr_strb,
   output logic [NUM_REQ-1:0]                    s_wr_data_ready,
   output logic [NUM_REQ-1:0]                    s_wr_done,
   idma_sync_256b_req_arbiter_if.master          idma,
   output logic                                  rd_busy,
   output logic                                  wr_busy,
   output logic [IDX_W-1:0]                      rd_owner,
   output logic [IDX_W-1:0]                      wr_owner
);
   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] CMD  = ST_CMD;
   localparam logic [1:0] DATA = ST_DATA;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
   endfunction

   logic [1:0]            rd_st, wr_st;
   logic [IDX_W-1:0]      rd_own, wr_own, rd_ptr, wr_ptr, rd_idx, wr_idx;
   logic [NUM_REQ-1:0]    rd_gnt, wr_gnt;
   logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
   logic [31:0]           rd_num_q, wr_num_q, rd_cnt, rd_beats;
   logic                  rd_cmd_hs, wr_cmd_hs, rd_beat_hs, wr_done_hit;

   idma_rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rd_arb (
      .req(s_rd_req), .ptr(rd_ptr), .gnt(rd_gnt), .idx(rd_idx));
   idma_rr_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_wr_arb (
      .req(s_wr_req), .ptr(wr_ptr), .gnt(wr_gnt), .idx(wr_idx));

   assign rd_beats    = num_to_beats(rd_num_q);
   assign rd_cmd_hs   = (rd_st == CMD) && idma.rd_addr_ready;
   assign wr_cmd_hs   = (wr_st == CMD) && idma.wr_addr_ready;
   assign rd_beat_hs  = (rd_st == DATA) && idma.rd_data_valid && idma.rd_data_ready;
   assign wr_done_hit = (wr_st == DATA) && idma.wr_done_intr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_st <= IDLE; rd_own <= '0; rd_ptr <= '0;
         rd_addr_q <= '0; rd_num_q <= '0; rd_cnt <= '0;
      end else begin
         case (rd_st)
            IDLE: if (|rd_gnt) begin
               rd_own    <= rd_idx;
               rd_addr_q <= s_rd_addr[rd_idx];
               rd_num_q  <= s_rd_num[rd_idx];
               rd_st     <= CMD;
            end
            CMD: if (idma.rd_addr_ready) begin
               rd_ptr <= next_idx(rd_own);
               rd_cnt <= rd_beats;
               rd_st  <= (rd_beats == '0) ? IDLE : DATA;
            end
            DATA: if (rd_beat_hs) begin
               rd_cnt <= rd_cnt - 1'b1;
               if (rd_cnt == 32'd1) rd_st <= IDLE;
            end
            default: rd_st <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_st <= IDLE; wr_own <= '0; wr_ptr <= '0;
         wr_addr_q <= '0; wr_num_q <= '0;
      end else begin
         case (wr_st)
            IDLE: if (|wr_gnt) begin
               wr_own    <= wr_idx;
               wr_addr_q <= s_wr_addr[wr_idx];
               wr_num_q  <= s_wr_num[wr_idx];
               wr_st     <= CMD;
            end
            CMD: if (idma.wr_addr_ready) begin
               wr_ptr <= next_idx(wr_own);
               wr_st  <= DATA;
            end
            DATA: if (idma.wr_done_intr) wr_st <= IDLE;
            default: wr_st <= IDLE;
         endcase
      end
   end

   assign idma.rd_req        = (rd_st == CMD);
   assign idma.rd_addr       = rd_addr_q;
   assign idma.rd_num        = rd_num_q;
   assign idma.rd_data_ready = (rd_st == DATA) && s_rd_data_ready[rd_own];
   assign idma.wr_req        = (wr_st == CMD);
   assign idma.wr_addr       = wr_addr_q;
   assign idma.wr_num        = wr_num_q;
   assign idma.wr_data_valid = (wr_st == DATA) && s_wr_data_valid[wr_own];
   assign idma.wr_data       = s_wr_data[wr_own];
   assign idma.wr_strb       = s_wr_strb[wr_own];
   assign s_rd_data          = idma.rd_data;

   // Per-requester return paths: only the locked owner ever sees a handshake.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
      assign s_rd_addr_ready[g] = rd_cmd_hs && (rd_own == IDX_W'(g));
      assign s_rd_data_valid[g] = (rd_st == DATA) && idma.rd_data_valid && (rd_own == IDX_W'(g));
      assign s_wr_addr_ready[g] = wr_cmd_hs && (wr_own == IDX_W'(g));
      assign s_wr_data_ready[g] = (wr_st == DATA) && idma.wr_data_ready && (wr_own == IDX_W'(g));
      assign s_wr_done[g]       = wr_done_hit && (wr_own == IDX_W'(g));
   end

   assign rd_busy  = (rd_st != IDLE);
   assign wr_busy  = (wr_st != IDLE);
   assign rd_owner = rd_own;
   assign wr_owner = wr_own;

endmodule

// File: tb/tb_idma_sync_256b_req_arbiter.sv
// Directed bench for the iDMA request arbiter with two requesters.
module tb_idma_sync_256b_req_arbiter;
   localparam int NR = 2;
   localparam int AW = 32;
   localparam int DW = 256;
   localparam int SW = DW / 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NR-1:0]          s_rd_req, s_rd_addr_ready, s_rd_data_valid, s_rd_data_ready;
   logic [NR-1:0][AW-1:0]  s_rd_addr, s_wr_addr;
   logic [NR-1:0][31:0]    s_rd_num, s_wr_num;
   logic [DW-1:0]          s_rd_data;
   logic [NR-1:0]          s_wr_req, s_wr_addr_ready, s_wr_data_valid, s_wr_data_ready, s_wr_done;
   logic [NR-1:0][DW-1:0]  s_wr_data;
   logic [NR-1:0][SW-1:0]  s_wr_strb;
   logic                   rd_busy, wr_busy;
   logic [0:0]             rd_owner, wr_owner;

   idma_sync_256b_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) ifc ();

   idma_sync_256b_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_rd_req(s_rd_req), .s_rd_addr(s_rd_addr), .s_rd_num(s_rd_num),
      .s_rd_addr_ready(s_rd_addr_ready), .s_rd_data_valid(s_rd_data_valid),
      .s_rd_data(s_rd_data), .s_rd_data_ready(s_rd_data_ready),
      .s_wr_req(s_wr_req), .s_wr_addr(s_wr_addr), .s_wr_num(s_wr_num),
      .s_wr_addr_ready(s_wr_addr_ready), .s_wr_data_valid(s_wr_data_valid),
      .s_wr_data(s_wr_data), .s_wr_strb(s_wr_strb), .s_wr_data_ready(s_wr_data_ready),
      .s_wr_done(s_wr_done), .idma(ifc),
      .rd_busy(rd_busy), .wr_busy(wr_busy), .rd_owner(rd_owner), .wr_owner(wr_owner));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clr_inputs();
      s_rd_req = '0; s_rd_addr = '0; s_rd_num = '0; s_rd_data_ready = '0;
      s_wr_req = '0; s_wr_addr = '0; s_wr_num = '0; s_wr_data_valid = '0;
      s_wr_data = '0; s_wr_strb = '0;
      ifc.rd_addr_ready = 0; ifc.rd_data_valid = 0; ifc.rd_data = '0;
      ifc.wr_addr_ready = 0; ifc.wr_data_ready = 0; ifc.wr_done_intr = 0;
   endtask

   task automatic do_reset();
      rst_n = 0; clr_inputs();
      tick(); tick();
      rst_n = 1;
   endtask

   // Full read by requester r: command, optional owner stall, then beats.
   task automatic do_read(input int r, input logic [31:0] addr, input logic [31:0] num,
                          input int beats, input int stall);
      logic [NR-1:0] own_bit;
      own_bit = NR'(1) << r;
      s_rd_addr[r] = addr; s_rd_num[r] = num; s_rd_req[r] = 1'b1;
      tick();
      chk("rd_req", ifc.rd_req, 1);
      chk("rd_owner", rd_owner, r);
      chk("rd_addr", ifc.rd_addr, addr);
      chk("rd_num", ifc.rd_num, num);
      ifc.rd_addr_ready = 1; #1;
      chk("rd_addr_ready_route", s_rd_addr_ready, own_bit);
      tick();
      s_rd_req[r] = 1'b0; ifc.rd_addr_ready = 0;
      chk("rd_busy_after_cmd", rd_busy, beats != 0);
      for (int s = 0; s < stall; s++) begin
         ifc.rd_data_valid = 1; s_rd_data_ready = ~own_bit; #1;
         chk("rd_stall_ready", ifc.rd_data_ready, 0);
         chk("rd_stall_busy", rd_busy, 1);
         tick();
      end
      for (int b = 0; b < beats; b++) begin
         ifc.rd_data_valid = 1; ifc.rd_data = {8{32'hA500_0000 + 32'(b)}};
         s_rd_data_ready = '1; #1;
         chk("rd_valid_route", s_rd_data_valid, own_bit);
         chk("rd_data", s_rd_data[63:0], {2{32'hA500_0000 + 32'(b)}});
         chk("rd_busy_beat", rd_busy, 1);
         tick();
      end
      chk("rd_busy_done", rd_busy, 0);
      chk("rd_valid_idle", s_rd_data_valid, 0);
      ifc.rd_data_valid = 0; s_rd_data_ready = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      do_reset();
      chk("rst_rd_req", ifc.rd_req, 0);
      chk("rst_wr_req", ifc.wr_req, 0);
      chk("rst_busy", {rd_busy, wr_busy}, 0);
      chk("rst_owner", {rd_owner, wr_owner}, 0);
      chk("rst_readies", {s_rd_addr_ready, s_wr_addr_ready, s_wr_data_ready}, 0);
      chk("rst_valid_done", {s_rd_data_valid, s_wr_done}, 0);

      // Single read, 32 words -> 4 beats
      do_read(0, 32'h1000, 32, 4, 0);

      // Simultaneous requests after reset: 0 then 1, twice
      do_reset();
      for (int rep = 0; rep < 2; rep++) begin
         s_rd_addr[1] = 32'h2000; s_rd_num[1] = 16; s_rd_req[1] = 1'b1;
         do_read(0, 32'h3000, 8, 1, 0);
         do_read(1, 32'h2000, 16, 2, 0);
      end

      // Done interrupt outside DATA is ignored
      ifc.wr_done_intr = 1; #1;
      chk("wr_done_idle", s_wr_done, 0);
      tick();
      chk("wr_busy_idle", wr_busy, 0);
      ifc.wr_done_intr = 0;

      // Concurrent read (req1, 2 beats) and write (req0, 3 beats)
      s_rd_addr[1] = 32'h4000; s_rd_num[1] = 16; s_rd_req[1] = 1;
      s_wr_addr[0] = 32'h5000; s_wr_num[0] = 24; s_wr_req[0] = 1;
      tick();
      chk("cc_reqs", {ifc.rd_req, ifc.wr_req}, 2'b11);
      chk("cc_owners", {rd_owner, wr_owner}, 2'b10);
      chk("cc_wr_addr", ifc.wr_addr, 32'h5000);
      chk("cc_wr_num", ifc.wr_num, 24);
      ifc.rd_addr_ready = 1; ifc.wr_addr_ready = 1; ifc.wr_done_intr = 1; #1;
      chk("cc_rd_ar", s_rd_addr_ready, 2'b10);
      chk("cc_wr_ar", s_wr_addr_ready, 2'b01);
      chk("cc_done_in_cmd", s_wr_done, 0);
      tick();
      s_rd_req = '0; s_wr_req = '0; ifc.wr_done_intr = 0;
      ifc.rd_addr_ready = 0; ifc.wr_addr_ready = 0;
      chk("cc_both_busy", {rd_busy, wr_busy}, 2'b11);
      for (int i = 0; i < 3; i++) begin
         ifc.rd_data_valid = (i < 2); s_rd_data_ready = 2'b10;
         s_wr_data_valid = 2'b01; ifc.wr_data_ready = 1;
         s_wr_data[0] = {8{32'hC0DE_0000 + 32'(i)}}; s_wr_data[1] = {8{32'hDEAD_BEEF}};
         s_wr_strb[0] = 32'hFFFF_0000 | 32'(i); s_wr_strb[1] = 32'h1234_5678; #1;
         chk("cc_wr_valid", ifc.wr_data_valid, 1);
         chk("cc_wr_data", ifc.wr_data[63:0], {2{32'hC0DE_0000 + 32'(i)}});
         chk("cc_wr_strb", ifc.wr_strb, 32'hFFFF_0000 | 32'(i));
         chk("cc_wr_ready_route", s_wr_data_ready, 2'b01);
         if (i < 2) chk("cc_rd_valid_route", s_rd_data_valid, 2'b10);
         tick();
      end
      chk("cc_rd_done_wr_busy", {rd_busy, wr_busy}, 2'b01);
      s_wr_data_valid = '0; ifc.wr_data_ready = 0; ifc.rd_data_valid = 0; s_rd_data_ready = '0;
      ifc.wr_done_intr = 1; #1;
      chk("cc_wr_done_pulse", s_wr_done, 2'b01);
      tick();
      ifc.wr_done_intr = 0; #1;
      chk("cc_wr_done_clear", s_wr_done, 0);
      chk("cc_wr_idle", wr_busy, 0);

      // Boundaries: zero-length and partial trailing beat
      do_read(0, 32'h6000, 0, 0, 0);
      do_read(1, 32'h6100, 9, 2, 0);

      // Backpressure: owner stalls 5 cycles before the first beat
      do_read(0, 32'h7000, 16, 2, 5);

      // Reset mid-transfer while requester 1 owns the read channel
      s_rd_addr[1] = 32'h8000; s_rd_num[1] = 32; s_rd_req[1] = 1;
      tick();
      ifc.rd_addr_ready = 1;
      tick();
      s_rd_req = '0; ifc.rd_addr_ready = 0;
      ifc.rd_data_valid = 1; s_rd_data_ready = 2'b10;
      tick();
      chk("mid_owner", rd_owner, 1);
      rst_n = 0; #1;
      chk("mid_rst_req", ifc.rd_req, 0);
      chk("mid_rst_busy", rd_busy, 0);
      chk("mid_rst_owner", rd_owner, 0);
      chk("mid_rst_valid", s_rd_data_valid, 0);
      clr_inputs();
      tick();
      rst_n = 1;
      do_read(1, 32'h9000, 8, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
